// File: rtl/sum4_stream_ctrl_pkg.sv
// Shared definitions for the four-sample running-sum stream controller.
// Holds the FSM state encoding and the default widths.
package sum4_stream_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;
  localparam int SUM_W      = DATA_W_DEF + 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/sum4_stream_ctrl_window.sv
// Sliding four-sample window: a three-deep history plus the incoming sample,
// summed into a registered result that only moves when a sample is shifted in.
module window_sum4 #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = DATA_W + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [SUM_W-1:0]  sum
);

  logic [DATA_W-1:0] h0_r;
  logic [DATA_W-1:0] h1_r;
  logic [DATA_W-1:0] h2_r;
  logic [SUM_W-1:0]  sum_r;
  logic [SUM_W-1:0]  add_s;

  // Full-width sum of the new sample and the three previous ones
  always_comb begin
    add_s = SUM_W'(din) + SUM_W'(h0_r) + SUM_W'(h1_r) + SUM_W'(h2_r);
  end

  // History shift/clear; the sum is left alone by clear so it holds across jobs
  always_ff @(posedge clk) begin
    if (reset) begin
      h0_r  <= '0;
      h1_r  <= '0;
      h2_r  <= '0;
      sum_r <= '0;
    end else begin
      if (clear) begin
        h0_r <= '0;
        h1_r <= '0;
        h2_r <= '0;
      end else if (shift_en) begin
        h2_r <= h1_r;
        h1_r <= h0_r;
        h0_r <= din;
      end
      if (shift_en) begin
        sum_r <= add_s;
      end
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/sum4_stream_ctrl.sv
// Job controller: accepts a length, streams that many samples through the
// four-sample window and pulses done when the last sample lands.
module sum4_stream_ctrl
  import sum4_stream_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W+1:0] out_sum,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = DATA_W + 2;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic             out_valid_r;
  logic             done_r;
  logic             start_ok_s;
  logic             accept_s;
  logic             last_s;

  // Handshake decode; a zero-length request never leaves IDLE
  always_comb begin
    start_ok_s = (state_r == ST_IDLE) && start && (len != {LEN_W{1'b0}});
    accept_s   = (state_r == ST_RUN) && in_valid;
    last_s     = accept_s && (cnt_r == (len_r - LEN_W'(1)));
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, job length capture, sample counter and output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      len_r       <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= accept_s;
      done_r      <= last_s;
      if (start_ok_s) begin
        len_r <= len;
        cnt_r <= '0;
      end else if (accept_s) begin
        cnt_r <= cnt_r + LEN_W'(1);
      end
    end
  end

  window_sum4 #(
    .DATA_W (DATA_W),
    .SUM_W  (OUT_W)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok_s),
    .shift_en (accept_s),
    .din      (in_data),
    .sum      (out_sum)
  );

  assign in_ready  = (state_r == ST_RUN);
  assign busy      = (state_r != ST_IDLE);
  assign out_valid = out_valid_r;
  assign done      = done_r;

endmodule

// File: tb/tb_sum4_stream_ctrl.sv
// Directed self-checking bench for sum4_stream_ctrl.
module tb_sum4_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_sum;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  sum4_stream_ctrl #(.DATA_W(8), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL job_start: busy=%b in_ready=%b required 1/1", busy, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0; in_data = 8'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_sum !== 10'd0 ||
        out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b sum=%0d ov=%b done=%b required 0/0/0/0/0",
               in_ready, busy, out_sum, out_valid, done);
    end
  endtask

  task automatic test_basic();
    int d[4] = '{100, 100, 0, 50};
    int e[4] = '{100, 200, 200, 250};
    begin_job(4'd4);
    len = 4'd1;  // must not shorten the running job
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(d[i]);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 10'(e[i]) || done !== (i == 3)) begin
        errors++;
        $display("FAIL basic_sum[%0d]: ov=%b sum=%0d done=%b required 1/%0d/%b",
                 i, out_valid, out_sum, done, e[i], (i == 3));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_state: busy=%b rdy=%b required 1/0", busy, in_ready);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_sum !== 10'd250) begin
      errors++;
      $display("FAIL basic_idle: busy=%b done=%b ov=%b sum=%0d required 0/0/0/250",
               busy, done, out_valid, out_sum);
    end
  endtask

  task automatic test_max();
    int e[6] = '{255, 510, 765, 1020, 1020, 1020};
    begin_job(4'd6);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'd255;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 10'(e[i]) || done !== (i == 5)) begin
        errors++;
        $display("FAIL max_sum[%0d]: ov=%b sum=%0d done=%b required 1/%0d/%b",
                 i, out_valid, out_sum, done, e[i], (i == 5));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int d[4] = '{10, 11, 5, 5};
    int e[4] = '{10, 21, 5, 10};
    for (int j = 0; j < 2; j++) begin
      begin_job(4'd2);
      for (int i = 0; i < 2; i++) begin
        in_valid = 1'b1; in_data = 8'(d[2*j+i]);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'(e[2*j+i])) begin
          errors++;
          $display("FAIL flush_sum[%0d]: ov=%b sum=%0d required 1/%0d",
                   2*j+i, out_valid, out_sum, e[2*j+i]);
        end
      end
      in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_gaps();
    logic v[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int   d[6] = '{1, 99, 99, 2, 99, 3};
    int   e[6] = '{1, 1, 1, 3, 3, 6};
    int   pulses = 0;
    begin_job(4'd3);
    for (int i = 0; i < 6; i++) begin
      in_valid = v[i]; in_data = 8'(d[i]);
      tick();
      if (out_valid === 1'b1) pulses++;
      checks++;
      if (out_valid !== v[i] || out_sum !== 10'(e[i]) || done !== (i == 5)) begin
        errors++;
        $display("FAIL gap_cycle[%0d]: ov=%b sum=%0d done=%b required %b/%0d/%b",
                 i, out_valid, out_sum, done, v[i], e[i], (i == 5));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL gap_pulses: got %0d required 3", pulses);
    end
    tick();
  endtask

  task automatic test_ignored();
    int dones = 0;
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_start: busy=%b ov=%b done=%b required 0/0/0", busy, out_valid, done);
    end
    begin_job(4'd2);
    start = 1'b1; len = 4'd5;
    in_valid = 1'b1; in_data = 8'd7;
    tick();
    if (done === 1'b1) dones++;
    in_data = 8'd8;
    tick();
    if (done === 1'b1) dones++;
    checks++;
    if (out_sum !== 10'd15 || done !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run_sum: sum=%0d done=%b required 15/1", out_sum, done);
    end
    in_valid = 1'b0;
    tick();  // leaves DONE with start still high
    if (done === 1'b1) dones++;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_not_queued: busy=%b required 0", busy);
    end
    tick(); tick();
    if (done === 1'b1) dones++;
    checks++;
    if (dones != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: dones=%0d busy=%b required 1/0", dones, busy);
    end
  endtask

  task automatic test_reset_mid();
    begin_job(4'd8);
    in_valid = 1'b1; in_data = 8'd3;
    tick();
    in_data = 8'd4;
    tick();
    checks++;
    if (out_sum !== 10'd7) begin
      errors++;
      $display("FAIL mid_pre_reset: sum=%0d required 7", out_sum);
    end
    reset = 1'b1; start = 1'b1; len = 4'd3; in_data = 8'd9;
    tick();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_sum !== 10'd0 ||
        done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b rdy=%b sum=%0d done=%b ov=%b required 0/0/0/0/0",
               busy, in_ready, out_sum, done, out_valid);
    end
    begin_job(4'd1);
    in_valid = 1'b1; in_data = 8'd6;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_sum !== 10'd6 || done !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_job: sum=%0d done=%b ov=%b required 6/1/1", out_sum, done, out_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_flush();
    test_gaps();
    test_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
